// File: rtl/seven_seg_scan_if.sv
// Display-side bus for the multiplexed seven-segment scanner.
// The master drives the value/control side; the slave (the scanner) drives the pins.
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    lz_suppress;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output enable, load, value, dp_in, lz_suppress,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  enable, load, value, dp_in, lz_suppress,
    output seg, dp, an, frame_start
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed N-digit seven-segment driver: prescaled digit scan, anti-ghost
// blanking at the start of every slot, tear-free value update at frame
// boundaries, leading-zero suppression and per-digit decimal points.
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  seven_seg_scan_if.slave     bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYCLES);

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [4*NUM_DIGITS-1:0] r_active_val;
  logic [NUM_DIGITS-1:0]   r_active_dp;
  logic                    r_pending;
  logic                    r_en_q;
  logic                    r_frame_start;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_presc_last;
  logic                    w_idx_last;
  logic                    w_boundary;
  logic                    w_in_blank;
  logic [NUM_DIGITS-1:0]   w_an_sel;
  logic [NUM_DIGITS-1:0]   w_hi_zero;
  logic [NUM_DIGITS-1:0]   w_blank_digit;
  logic [6:0]              w_seg_digit [NUM_DIGITS];

  assign w_presc_last = (r_presc == PRESC_LAST);
  assign w_idx_last   = (r_idx == IDX_LAST);
  // Last cycle of the last digit slot; the active image may only change here.
  assign w_boundary   = bus.enable & w_presc_last & w_idx_last;
  // Anodes stay off while disabled and for the first cycles of each slot.
  assign w_in_blank   = ~bus.enable | (r_presc < BLANK_LIM);

  // Per-digit decode, leading-zero detection and anode pattern.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      // Digit gi and everything to its left are zero.
      assign w_hi_zero[gi] = (r_active_val[4*NUM_DIGITS-1:4*gi] == '0);
      if (gi == 0) begin : g_lsd
        // The rightmost digit always shows, so zero reads as "0".
        assign w_blank_digit[gi] = 1'b0;
      end else begin : g_upper
        assign w_blank_digit[gi] = bus.lz_suppress & w_hi_zero[gi];
      end
      assign w_seg_digit[gi] = w_blank_digit[gi] ? 7'h7F
                                                 : hex_to_seg(r_active_val[4*gi +: 4]);
      assign w_an_sel[gi]    = (r_idx != IW'(gi));
    end
  endgenerate

  // Slot prescaler and digit index; disable parks both at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (!bus.enable) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_presc_last) begin
      r_presc <= '0;
      r_idx   <= w_idx_last ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Shadow capture on load; shadow moves to active only at a frame boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_active_val <= '0;
      r_active_dp  <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (bus.load) begin
        r_shadow_val <= bus.value;
        r_shadow_dp  <= bus.dp_in;
      end
      if (w_boundary && r_pending) begin
        r_active_val <= r_shadow_val;
        r_active_dp  <= r_shadow_dp;
      end
      // A load on the boundary itself stays pending for the next frame.
      if (bus.load) begin
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Frame pulse: after each last-slot wrap, and once when scanning restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en_q        <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_en_q        <= bus.enable;
      r_frame_start <= bus.enable & (w_boundary | ~r_en_q);
    end
  end

  // Registered pin drive from the current (idx, presc) state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an  <= '1;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else if (w_in_blank) begin
      r_an  <= '1;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_sel;
      r_seg <= w_seg_digit[r_idx];
      r_dp  <= ~r_active_dp[r_idx];
    end
  end

  assign bus.seg         = r_seg;
  assign bus.dp          = r_dp;
  assign bus.an          = r_an;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
module tb_seven_seg_scan;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  seven_seg_scan_if #(.NUM_DIGITS(4)) bus ();

  seven_seg_scan #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One-cycle load strobe.
  task automatic load_pulse(input logic [15:0] v, input logic [3:0] d);
    bus.value  = v;
    bus.dp_in  = d;
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
    $display("load value=%04h dp_in=%04b", v, d);
  endtask

  // Steady-state frame start: pulse while digit 3 is still on the pins.
  task automatic wait_anchor(output bit found);
    found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      tick();
      if (bus.frame_start === 1'b1 && bus.an === 4'b0111) found = 1'b1;
    end
  endtask

  // Check one full frame: blank slot start, then the digit with its seg/dp.
  task automatic check_frame(input string name, input logic [27:0] exp_seg, input logic [3:0] exp_dp);
    bit         found;
    int         slot;
    int         pos;
    logic [3:0] one;
    logic [3:0] exp_an;
    wait_anchor(found);
    check_eq({name, "_anchor"}, 32'(found), 32'd1);
    one = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      tick();
      slot = (k - 1) / 4;
      pos  = (k - 1) % 4;
      if (pos == 0) begin
        check_eq({name, "_blank_an"},  32'(bus.an),  32'hF);
        check_eq({name, "_blank_seg"}, 32'(bus.seg), 32'h7F);
      end else if (pos == 2) begin
        exp_an = ~(one << slot);
        check_eq({name, "_an"},  32'(bus.an),  32'(exp_an));
        check_eq({name, "_seg"}, 32'(bus.seg), 32'(exp_seg[7*slot +: 7]));
        check_eq({name, "_dp"},  32'(bus.dp),  32'(exp_dp[slot]));
      end
      if (k == 8)  check_eq({name, "_fs_mid"}, 32'(bus.frame_start), 32'd0);
      if (k == 16) check_eq({name, "_fs_16"},  32'(bus.frame_start), 32'd1);
    end
    $display("frame %s checked", name);
  endtask

  initial begin
    bit         found;
    int         cnt79;
    logic [3:0] seq_exp [6];
    n_checks = 0;
    n_errors = 0;

    reset_n         = 1'b0;
    bus.enable      = 1'b0;
    bus.load        = 1'b0;
    bus.value       = '0;
    bus.dp_in       = '0;
    bus.lz_suppress = 1'b0;
    repeat (3) tick();
    check_eq("rst_an",  32'(bus.an),          32'hF);
    check_eq("rst_seg", 32'(bus.seg),         32'h7F);
    check_eq("rst_dp",  32'(bus.dp),          32'd1);
    check_eq("rst_fs",  32'(bus.frame_start), 32'd0);
    $display("reset state checked");

    // Release and start scanning: first two slots' anode pattern.
    reset_n    = 1'b1;
    bus.enable = 1'b1;
    seq_exp[0] = 4'b1111; seq_exp[1] = 4'b1110; seq_exp[2] = 4'b1110;
    seq_exp[3] = 4'b1110; seq_exp[4] = 4'b1111; seq_exp[5] = 4'b1101;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("start_an_seq", 32'(bus.an), 32'(seq_exp[i]));
    end
    $display("startup anode sequence checked");
    check_frame("zeros", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

    // Mid-frame load: current frame keeps old image.
    repeat (2) tick();
    load_pulse(16'h1A3F, 4'b0100);
    check_eq("hold_d0_seg", 32'(bus.seg), 32'h40);
    repeat (4) tick();
    check_eq("hold_d1_an",  32'(bus.an),  32'hD);
    check_eq("hold_d1_seg", 32'(bus.seg), 32'h40);
    check_frame("v1A3F", {7'h79, 7'h08, 7'h30, 7'h0E}, 4'b1011);

    // Leading-zero suppression.
    bus.lz_suppress = 1'b1;
    load_pulse(16'h0050, 4'b0000);
    check_frame("lz0050", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111);
    load_pulse(16'h0000, 4'b0000);
    check_frame("lz0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
    bus.lz_suppress = 1'b0;

    // Two loads in one frame: the later one wins, the earlier never shows.
    load_pulse(16'h1111, 4'b0000);
    load_pulse(16'h2222, 4'b0000);
    cnt79 = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.an !== 4'hF && bus.seg === 7'h79) cnt79++;
    end
    check_eq("no_79", 32'(cnt79), 32'd0);
    check_frame("v2222", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);

    // Drop enable in the middle of digit 1's slot.
    repeat (6) tick();
    bus.enable = 1'b0;
    tick();
    check_eq("dis_an",  32'(bus.an),  32'hF);
    check_eq("dis_seg", 32'(bus.seg), 32'h7F);
    check_eq("dis_dp",  32'(bus.dp),  32'd1);
    repeat (4) tick();
    check_eq("dis_hold_an", 32'(bus.an),          32'hF);
    check_eq("dis_hold_fs", 32'(bus.frame_start), 32'd0);
    $display("disable checked");

    // Re-enable: restart pulse, then digit 0 is the first lit digit.
    bus.enable = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      tick();
      if (bus.frame_start === 1'b1) found = 1'b1;
    end
    check_eq("reen_fs", 32'(found), 32'd1);
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      if (bus.an !== 4'hF) found = 1'b1;
      else tick();
    end
    check_eq("reen_lit",    32'(found),   32'd1);
    check_eq("reen_first_an",  32'(bus.an),  32'hE);
    check_eq("reen_first_seg", 32'(bus.seg), 32'h24);
    $display("re-enable checked");
    check_frame("reen2222", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);

    // Asynchronous reset mid-frame with a load pending.
    repeat (5) tick();
    load_pulse(16'h3333, 4'b1111);
    repeat (2) tick();
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_an",  32'(bus.an),          32'hF);
    check_eq("arst_seg", 32'(bus.seg),         32'h7F);
    check_eq("arst_dp",  32'(bus.dp),          32'd1);
    check_eq("arst_fs",  32'(bus.frame_start), 32'd0);
    $display("async reset checked");
    repeat (2) tick();
    reset_n = 1'b1;
    check_frame("post_rst", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
